// File: rtl/wrap_counter_pkg.sv
// Shared encodings for the wrap_counter_n LED position counter.
package wrap_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_SAT    = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/wrap_counter_n_tick_prescaler.sv
// Divide-by-(div+1) tick generator; counts only while run is high.
module tick_prescaler #(
    parameter int DIV_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;
    logic             tick_reg;

    // >= rather than == so a div lowered below the running count restarts at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (run) begin
            if (cnt_reg >= div) begin
                cnt_reg  <= '0;
                tick_reg <= 1'b1;
            end else begin
                cnt_reg  <= cnt_reg + 1'b1;
                tick_reg <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/wrap_counter_n.sv
// Bounded up/down position counter with wrap, bounce and saturate modes,
// a built-in tick prescaler, synchronous load and a boundary-event pulse.
module wrap_counter_n
    import wrap_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pause,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] step,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir_state,
    output logic             tick,
    output logic             evt,
    output logic             err
);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             dir_reg, dir_next;
    logic             event_reg, event_next;
    logic             err_reg;
    mode_e            mode_q_reg;
    mode_e            mode_cur;
    logic             run, tick_raw;

    assign mode_cur = mode_e'(mode);
    assign run      = en & ~pause & ~err_reg;

    tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (load),
        .div  (div),
        .tick (tick_raw)
    );

    // One extra bit so count+step and lo+step cannot overflow silently
    logic [WIDTH:0]   up_sum, lo_sum;
    logic [WIDTH-1:0] inc_sat, dec_sat, load_clamped;
    logic             in_range, entering, up;

    assign up_sum   = {1'b0, count_reg} + {1'b0, step};
    assign lo_sum   = {1'b0, lo} + {1'b0, step};
    assign inc_sat  = (up_sum > {1'b0, hi}) ? hi : up_sum[WIDTH-1:0];
    assign dec_sat  = ({1'b0, count_reg} < lo_sum) ? lo : (count_reg - step);
    assign in_range = (count_reg >= lo) && (count_reg <= hi);

    assign load_clamped = (load_val < lo) ? lo : ((load_val > hi) ? hi : load_val);

    // Bounce keeps its own direction, seeded from the input on entry to the mode
    assign entering = (mode_cur == MODE_BOUNCE) && (mode_q_reg != MODE_BOUNCE);
    assign up       = (mode_cur == MODE_BOUNCE) ? (entering ? direction : dir_reg) : direction;

    always_comb begin
        count_next = count_reg;
        dir_next   = up;
        event_next = 1'b0;
        if (run && tick_raw && (mode_cur != MODE_HOLD)) begin
            if (!in_range) begin
                count_next = up ? lo : hi;
                event_next = 1'b1;
            end else if (step != '0) begin
                case (mode_cur)
                    MODE_WRAP: begin
                        if (up) begin
                            if (up_sum > {1'b0, hi}) begin
                                count_next = lo;
                                event_next = 1'b1;
                            end else begin
                                count_next = up_sum[WIDTH-1:0];
                            end
                        end else if ({1'b0, count_reg} < lo_sum) begin
                            count_next = hi;
                            event_next = 1'b1;
                        end else begin
                            count_next = count_reg - step;
                        end
                    end
                    MODE_BOUNCE: begin
                        if (up) begin
                            if (count_reg == hi) begin
                                dir_next   = DIR_DOWN;
                                count_next = dec_sat;
                                event_next = 1'b1;
                            end else begin
                                count_next = inc_sat;
                            end
                        end else if (count_reg == lo) begin
                            dir_next   = DIR_UP;
                            count_next = inc_sat;
                            event_next = 1'b1;
                        end else begin
                            count_next = dec_sat;
                        end
                    end
                    MODE_SAT: begin
                        count_next = up ? inc_sat : dec_sat;
                        event_next = (count_next != count_reg) && (count_next == (up ? hi : lo));
                    end
                    default: begin
                        count_next = count_reg;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            dir_reg    <= DIR_UP;
            event_reg  <= 1'b0;
            err_reg    <= 1'b0;
            mode_q_reg <= MODE_WRAP;
        end else begin
            err_reg <= (lo > hi);
            if (load) begin
                count_reg  <= load_clamped;
                dir_reg    <= direction;
                event_reg  <= 1'b0;
                mode_q_reg <= mode_cur;
            end else if (err_reg) begin
                event_reg <= 1'b0;
            end else begin
                count_reg  <= count_next;
                dir_reg    <= dir_next;
                event_reg  <= event_next;
                mode_q_reg <= mode_cur;
            end
        end
    end

    // An update landing on the edge that raises err must not leak a visible pulse
    assign count     = count_reg;
    assign dir_state = dir_reg;
    assign tick      = tick_raw & ~err_reg;
    assign evt       = event_reg & ~err_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_wrap_counter_n.sv
// Self-checking bench for wrap_counter_n: directed scenarios plus randomized
// stimulus compared every cycle against an integer-arithmetic reference model.
module tb_wrap_counter_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, pause = 1'b0, direction = 1'b1, load = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  lo = 8'd0, hi = 8'd255, step = 8'd1, load_val = 8'd0;
    logic [26:0] div = 27'd0;
    logic [7:0]  count;
    logic        dir_state, tick, evt, err;

    int checks = 0;
    int errors = 0;
    string phase = "init";

    // Reference model state
    int m_count, m_dir, m_pc, m_tr, m_ev, m_err, m_modeq;
    int exp_c[5];
    int exp_e[5];

    wrap_counter_n #(.WIDTH(8), .DIV_W(27)) dut (
        .clk(clk), .rst(rst), .en(en), .pause(pause), .direction(direction),
        .mode(mode), .lo(lo), .hi(hi), .step(step), .div(div), .load(load),
        .load_val(load_val), .count(count), .dir_state(dir_state), .tick(tick),
        .evt(evt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s/%s got %0d expected %0d", phase, tag, got, want);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_count = 0; m_dir = 1; m_pc = 0; m_tr = 0; m_ev = 0; m_err = 0; m_modeq = 0;
    endtask

    // Advance the model by one clock edge from the inputs currently applied
    task automatic model_step();
        int l, h, s, d, md, c, nd, ev, pcn, trn, run, tickv, up;
        if (rst) begin
            model_reset();
            return;
        end
        l = int'(lo); h = int'(hi); s = int'(step); d = int'(div); md = int'(mode);
        run   = (en && !pause && m_err == 0) ? 1 : 0;
        tickv = (m_tr != 0 && m_err == 0) ? 1 : 0;
        pcn = m_pc; trn = 0;
        if (load) begin
            pcn = 0;
        end else if (run != 0) begin
            if (m_pc >= d) begin pcn = 0; trn = 1; end
            else pcn = m_pc + 1;
        end
        c = m_count; nd = m_dir; ev = 0;
        if (load) begin
            c = (int'(load_val) < l) ? l : ((int'(load_val) > h) ? h : int'(load_val));
            nd = int'(direction);
            m_modeq = md;
        end else if (m_err == 0) begin
            if (md == 1) up = (m_modeq != 1) ? int'(direction) : m_dir;
            else         up = int'(direction);
            nd = up;
            if (run != 0 && tickv != 0 && md != 3) begin
                if (c < l || c > h) begin
                    c = (up != 0) ? l : h;
                    ev = 1;
                end else if (s != 0) begin
                    if (md == 0) begin
                        if (up != 0) begin
                            if (c + s > h) begin c = l; ev = 1; end else c = c + s;
                        end else begin
                            if (c - s < l) begin c = h; ev = 1; end else c = c - s;
                        end
                    end else if (md == 1) begin
                        if (up != 0) begin
                            if (c == h) begin nd = 0; c = imax(c - s, l); ev = 1; end
                            else c = imin(c + s, h);
                        end else begin
                            if (c == l) begin nd = 1; c = imin(c + s, h); ev = 1; end
                            else c = imax(c - s, l);
                        end
                    end else begin
                        int bound, nc;
                        bound = (up != 0) ? h : l;
                        nc = (up != 0) ? imin(c + s, h) : imax(c - s, l);
                        ev = (nc != c && nc == bound) ? 1 : 0;
                        c = nc;
                    end
                end
            end
            m_modeq = md;
        end
        m_count = c; m_dir = nd; m_ev = ev;
        m_pc = pcn; m_tr = trn;
        m_err = (l > h) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("count", int'(count), m_count);
        check("dir_state", int'(dir_state), m_dir);
        check("tick", int'(tick), (m_tr != 0 && m_err == 0) ? 1 : 0);
        check("evt", int'(evt), (m_ev != 0 && m_err == 0) ? 1 : 0);
        check("err", int'(err), m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic setup(input int l, input int h, input int s, input int d,
                         input int md, input int dv, input int lv);
        lo = 8'(l); hi = 8'(h); step = 8'(s); div = 27'(d); mode = 2'(md);
        direction = dv[0]; en = 1'b1; pause = 1'b0; load = 1'b1; load_val = 8'(lv);
        cycle();
        load = 1'b0;
        $display("txn %s load %0d lo=%0d hi=%0d step=%0d div=%0d mode=%0d dir=%0d count=%0d",
                 phase, lv, l, h, s, d, md, dv, count);
    endtask

    // Checks the first n tick-driven updates following a load
    task automatic expect_seq(input int d, input int n);
        cycle();
        for (int i = 0; i < n; i++) begin
            repeat (d + 1) cycle();
            check($sformatf("upd%0d_count", i), int'(count), exp_c[i]);
            check($sformatf("upd%0d_evt", i), int'(evt), exp_e[i]);
            $display("txn %s update %0d count=%0d evt=%0d dir=%0d", phase, i, count, evt, dir_state);
        end
    endtask

    initial begin
        model_reset();
        phase = "reset";
        repeat (2) cycle();
        rst = 1'b0;

        // Asynchronous reset between edges
        phase = "async_rst";
        setup(0, 255, 1, 0, 0, 1, 37);
        en = 1'b0;
        cycle();
        check("pre_count", int'(count), 37);
        #2 rst = 1'b1;
        #1;
        check("rst_count", int'(count), 0);
        check("rst_dir", int'(dir_state), 1);
        check("rst_tick", int'(tick), 0);
        check("rst_evt", int'(evt), 0);
        model_reset();
        cycle();
        rst = 1'b0;
        $display("txn async reset applied and released");

        phase = "wrap_up";
        setup(2, 9, 3, 0, 0, 1, 2);
        exp_c = '{5, 8, 2, 5, 0}; exp_e = '{0, 0, 1, 0, 0};
        expect_seq(0, 4);

        phase = "wrap_down";
        setup(2, 9, 3, 0, 0, 0, 3);
        exp_c = '{9, 6, 3, 9, 0}; exp_e = '{1, 0, 0, 1, 0};
        expect_seq(0, 4);

        phase = "bounce";
        setup(0, 5, 2, 0, 1, 1, 4);
        exp_c = '{5, 3, 1, 0, 2}; exp_e = '{0, 1, 0, 0, 1};
        expect_seq(0, 5);

        phase = "saturate";
        setup(0, 10, 4, 2, 2, 1, 0);
        exp_c = '{4, 8, 10, 10, 0}; exp_e = '{0, 0, 1, 0, 0};
        expect_seq(2, 4);

        phase = "pause";
        setup(0, 200, 1, 3, 0, 1, 10);
        repeat (3) cycle();
        pause = 1'b1;
        repeat (4) cycle();
        check("paused_count", int'(count), 10);
        check("paused_tick", int'(tick), 0);
        pause = 1'b0;
        repeat (2) cycle();
        check("resumed_count", int'(count), 11);

        phase = "load_tick";
        setup(2, 9, 1, 0, 0, 1, 3);
        repeat (3) cycle();
        check("tick_live", int'(tick), 1);
        load = 1'b1; load_val = 8'd7;
        cycle();
        load = 1'b0;
        check("load_wins", int'(count), 7);
        load = 1'b1; load_val = 8'd200;
        cycle();
        load = 1'b0;
        check("load_clamp", int'(count), 9);

        phase = "err";
        setup(0, 50, 1, 0, 0, 1, 20);
        cycle();
        lo = 8'd7; hi = 8'd3;
        repeat (2) cycle();
        check("err_flag", int'(err), 1);
        repeat (4) cycle();
        check("err_frozen", int'(count), 7);
        lo = 8'd0; hi = 8'd50;
        repeat (2) cycle();

        phase = "oob";
        setup(5, 40, 0, 0, 0, 1, 30);
        cycle();
        hi = 8'd20; step = 8'd1;
        cycle();
        check("recover_count", int'(count), 5);
        check("recover_evt", int'(evt), 1);

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            pause = ($urandom_range(0, 9) == 0);
            load  = ($urandom_range(0, 24) == 0);
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0)  direction = ~direction;
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                lo = 8'($urandom_range(0, 100));
                hi = 8'($urandom_range(50, 255));
            end
            if ($urandom_range(0, 49) == 0) step = 8'($urandom_range(0, 40));
            if ($urandom_range(0, 49) == 0) div = 27'($urandom_range(0, 3));
            if (load)
                $display("txn random load %0d mode=%0d lo=%0d hi=%0d", load_val, mode, lo, hi);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
